// File: rtl/mem_stage_ext.sv
// mem_stage_ext: memory pipeline stage with load-wait handling.
// Holds one EX->MEM entry, waits for the load response, extracts and
// extends the loaded byte/half/word/dword, and drives the WB and ID
// bypass ports.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flush               squash the entry held in this stage
//   stall[SW]           pipeline stall vector (1 = stop)
//   ex_*                entry presented by the EX stage
//   dmem_rvalid/rdata   load response, little-endian
//   mem_stallreq        stage needs the pipeline held (load pending)
//   mem_timeout         one-cycle pulse after a load gave up waiting
//   fwd_*               write-back value for the ID bypass
//   wb_*                entry presented to write-back
//
// state  | meaning
// S_IDLE | entry freshly registered, nothing received yet
// S_WAIT | load issued, waiting for dmem_rvalid (wait counter running)
// S_DONE | load finished (data or timeout); load buffer drives result
module mem_stage_ext #(
   parameter int DW       = 32,
   parameter int SW       = 6,
   parameter int SIDX     = 3,
   parameter int MAX_WAIT = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic [SW-1:0]             stall,
   input  logic                      ex_valid,
   input  logic [31:0]               ex_pc,
   input  logic                      ex_mem_en,
   input  logic                      ex_mem_we,
   input  logic [1:0]                ex_size,
   input  logic                      ex_sext,
   input  logic [$clog2(DW/8)-1:0]   ex_addr_lo,
   input  logic                      ex_rf_we,
   input  logic [4:0]                ex_rf_waddr,
   input  logic [DW-1:0]             ex_result,
   input  logic                      dmem_rvalid,
   input  logic [DW-1:0]             dmem_rdata,
   output logic                      mem_stallreq,
   output logic                      mem_timeout,
   output logic                      fwd_we,
   output logic [4:0]                fwd_waddr,
   output logic [DW-1:0]             fwd_wdata,
   output logic                      wb_valid,
   output logic [31:0]               wb_pc,
   output logic                      wb_rf_we,
   output logic [4:0]                wb_rf_waddr,
   output logic [DW-1:0]             wb_rf_wdata
);

   localparam int AW = $clog2(DW/8);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   logic          r_valid, r_mem_en, r_mem_we, r_sext, r_rf_we;
   logic [31:0]   r_pc;
   logic [1:0]    r_size;
   logic [AW-1:0] r_addr_lo;
   logic [4:0]    r_rf_waddr;
   logic [DW-1:0] r_result;

   state_t        state, state_n;
   logic [7:0]    wait_cnt;
   logic [DW-1:0] load_buf;
   logic          timeout_q;

   logic          is_load, adv, bubble, rv, cnt_at_lim, timeout_now, stallreq;
   logic [1:0]    eff_size;
   logic [AW-1:0] lane_mask, lane;
   logic [DW-1:0] shifted, ext_data, load_data, rf_wdata;

   // Only two bits of the stall vector concern this stage; the rest are
   // folded here so the unused bits are visibly accounted for.
   logic unused_stall;
   assign unused_stall = ^stall;

   assign bubble = stall[SIDX] & ~stall[SIDX+1];
   // Register changes on load (!stall[SIDX]) or bubble; both reduce to this.
   assign adv    = rst | flush | ~stall[SIDX] | ~stall[SIDX+1];

   always_ff @(posedge clk) begin
      if (rst || flush || bubble) begin
         r_valid    <= 1'b0;
         r_pc       <= '0;
         r_mem_en   <= 1'b0;
         r_mem_we   <= 1'b0;
         r_size     <= '0;
         r_sext     <= 1'b0;
         r_addr_lo  <= '0;
         r_rf_we    <= 1'b0;
         r_rf_waddr <= '0;
         r_result   <= '0;
      end else if (!stall[SIDX]) begin
         r_valid    <= ex_valid;
         r_pc       <= ex_pc;
         r_mem_en   <= ex_mem_en;
         r_mem_we   <= ex_mem_we;
         r_size     <= ex_size;
         r_sext     <= ex_sext;
         r_addr_lo  <= ex_addr_lo;
         r_rf_we    <= ex_rf_we;
         r_rf_waddr <= ex_rf_waddr;
         r_result   <= ex_result;
      end
   end

   assign is_load    = r_valid & r_mem_en & ~r_mem_we;
   assign cnt_at_lim = (wait_cnt == 8'(MAX_WAIT - 1));
   // Responses with nothing pending (e.g. arriving after a flush) are dropped.
   assign rv         = dmem_rvalid & is_load & (state != S_DONE);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n     = state;
      stallreq    = 1'b0;
      timeout_now = 1'b0;
      if (is_load && state != S_DONE && !rv && !(state == S_WAIT && cnt_at_lim))
         stallreq = 1'b1;
      if (is_load && state == S_WAIT && cnt_at_lim && !dmem_rvalid)
         timeout_now = 1'b1;
      if (adv) begin
         state_n = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (is_load) state_n = rv ? S_DONE : S_WAIT;
            S_WAIT:  if (rv || timeout_now) state_n = S_DONE;
            default: state_n = state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || state_n != S_WAIT || state != S_WAIT)
         wait_cnt <= '0;
      else if (wait_cnt != 8'hFF)
         wait_cnt <= wait_cnt + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (adv)              load_buf <= '0;
      else if (rv)          load_buf <= ext_data;
      else if (timeout_now) load_buf <= '0;
   end

   // Flush and reset abandon a timing-out load without reporting it.
   always_ff @(posedge clk) begin
      if (rst) timeout_q <= 1'b0;
      else     timeout_q <= timeout_now & ~flush;
   end

   always_comb begin
      eff_size = r_size;
      if (DW == 32 && r_size == 2'd3) eff_size = 2'd2;
      lane_mask = AW'((32'd1 << eff_size) - 32'd1);
      lane      = r_addr_lo & ~lane_mask;
      shifted   = dmem_rdata >> {lane, 3'b000};
      ext_data  = shifted;
      case (eff_size)
         2'd0:    ext_data = r_sext ? DW'($signed(shifted[7:0]))  : DW'(shifted[7:0]);
         2'd1:    ext_data = r_sext ? DW'($signed(shifted[15:0])) : DW'(shifted[15:0]);
         2'd2:    ext_data = r_sext ? DW'($signed(shifted[31:0])) : DW'(shifted[31:0]);
         default: ext_data = shifted;
      endcase
   end

   assign load_data = rv ? ext_data : load_buf;
   assign rf_wdata  = is_load ? load_data : r_result;

   assign mem_stallreq = stallreq;
   assign mem_timeout  = timeout_q;
   assign wb_valid     = r_valid & ~stallreq;
   assign wb_pc        = r_pc;
   assign wb_rf_we     = r_rf_we & wb_valid;
   assign wb_rf_waddr  = r_rf_waddr;
   assign wb_rf_wdata  = rf_wdata;
   assign fwd_we       = r_rf_we & wb_valid;
   assign fwd_waddr    = r_rf_waddr;
   assign fwd_wdata    = rf_wdata;

endmodule
